// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: tag allocation, CDB capture,
// operand query with CDB bypass, single in-order retire and flush.
module reorder_buffer #(
    parameter int ROB_SZ_LOG = 4,
    parameter int REG_SZ_LOG = 4,
    localparam int SIZE = 2 ** ROB_SZ_LOG,
    localparam int TW = ROB_SZ_LOG + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  in_valid,
    input  logic [1:0]            in_type,
    input  logic [REG_SZ_LOG:0]   in_rd,
    input  logic                  in_pred,
    output logic                  full,
    output logic [TW-1:0]         tail,
    input  logic [TW-1:0]         q1_tag,
    input  logic [TW-1:0]         q2_tag,
    output logic                  q1_rdy,
    output logic                  q2_rdy,
    output logic [31:0]           q1_val,
    output logic [31:0]           q2_val,
    input  logic                  cdb_valid,
    input  logic [TW-1:0]         cdb_tag,
    input  logic [31:0]           cdb_val,
    input  logic                  cdb_taken,
    output logic                  run_upd,
    output logic [REG_SZ_LOG:0]   commit_rd,
    output logic [31:0]           res,
    output logic [TW-1:0]         head,
    output logic                  st_commit,
    output logic                  reset,
    output logic [31:0]           flush_pc
);

    typedef logic [ROB_SZ_LOG-1:0] idx_t;

    logic [SIZE-1:0]       valid_q, ready_q, pred_q, taken_q;
    logic [1:0]            type_q [SIZE];
    logic [REG_SZ_LOG:0]   rd_q   [SIZE];
    logic [31:0]           val_q  [SIZE];

    idx_t                  head_idx_q, head_idx_d;
    idx_t                  tail_idx_q, tail_idx_d;
    logic [TW-1:0]         count_q, count_d;

    logic                  run_upd_q, st_commit_q, reset_q;
    logic [REG_SZ_LOG:0]   commit_rd_q;
    logic [31:0]           res_q, flush_pc_q;
    logic [TW-1:0]         head_q;

    logic live, do_flush, do_issue, do_cdb, do_commit;
    idx_t cdb_idx, q1_idx, q2_idx;
    logic q1_byp, q2_byp;

    // Tag t maps to entry t-1; low-bit wrap makes tag SIZE land on SIZE-1.
    assign cdb_idx = cdb_tag[ROB_SZ_LOG-1:0] - 1'b1;
    assign q1_idx  = q1_tag[ROB_SZ_LOG-1:0] - 1'b1;
    assign q2_idx  = q2_tag[ROB_SZ_LOG-1:0] - 1'b1;

    assign full = (count_q == TW'(SIZE));
    assign tail = {1'b0, tail_idx_q} + TW'(1);

    assign live      = rdy && !reset_q;
    assign do_flush  = rdy && reset_q;
    assign do_issue  = live && in_valid && !full;
    assign do_cdb    = live && cdb_valid && (cdb_tag != '0) && valid_q[cdb_idx];
    assign do_commit = live && valid_q[head_idx_q] && ready_q[head_idx_q];

    // Operand queries, with same-cycle CDB bypass.
    assign q1_byp = cdb_valid && (cdb_tag == q1_tag);
    assign q2_byp = cdb_valid && (cdb_tag == q2_tag);
    assign q1_rdy = (q1_tag != '0) && valid_q[q1_idx] && (ready_q[q1_idx] || q1_byp);
    assign q2_rdy = (q2_tag != '0) && valid_q[q2_idx] && (ready_q[q2_idx] || q2_byp);
    assign q1_val = q1_byp ? cdb_val : val_q[q1_idx];
    assign q2_val = q2_byp ? cdb_val : val_q[q2_idx];

    // Retire pulses are masked while the pipeline is stalled.
    assign run_upd   = run_upd_q && rdy;
    assign st_commit = st_commit_q && rdy;
    assign reset     = reset_q && rdy;
    assign commit_rd = commit_rd_q;
    assign res       = res_q;
    assign head      = head_q;
    assign flush_pc  = flush_pc_q;

    // Next head/tail pointers and occupancy.
    always_comb begin
        head_idx_d = head_idx_q;
        tail_idx_d = tail_idx_q;
        count_d    = count_q;
        if (do_flush) begin
            head_idx_d = '0;
            tail_idx_d = '0;
            count_d    = '0;
        end else begin
            if (do_issue)  tail_idx_d = tail_idx_q + 1'b1;
            if (do_commit) head_idx_d = head_idx_q + 1'b1;
            if (do_issue && !do_commit) count_d = count_q + 1'b1;
            if (!do_issue && do_commit) count_d = count_q - 1'b1;
        end
    end

    // Pointer and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_idx_q <= '0;
            tail_idx_q <= '0;
            count_q    <= '0;
        end else begin
            head_idx_q <= head_idx_d;
            tail_idx_q <= tail_idx_d;
            count_q    <= count_d;
        end
    end

    // Entry storage: allocate on issue, capture from CDB, free on retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            ready_q <= '0;
            pred_q  <= '0;
            taken_q <= '0;
            for (int i = 0; i < SIZE; i++) begin
                type_q[i] <= '0;
                rd_q[i]   <= '0;
                val_q[i]  <= '0;
            end
        end else if (do_flush) begin
            valid_q <= '0;
        end else begin
            if (do_issue) begin
                valid_q[tail_idx_q] <= 1'b1;
                ready_q[tail_idx_q] <= (in_type == 2'd3);
                type_q[tail_idx_q]  <= in_type;
                rd_q[tail_idx_q]    <= in_rd;
                pred_q[tail_idx_q]  <= in_pred;
                taken_q[tail_idx_q] <= 1'b0;
            end
            if (do_cdb) begin
                ready_q[cdb_idx] <= 1'b1;
                val_q[cdb_idx]   <= cdb_val;
                taken_q[cdb_idx] <= cdb_taken;
            end
            if (do_commit) valid_q[head_idx_q] <= 1'b0;
        end
    end

    // Registered retire outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_upd_q   <= 1'b0;
            st_commit_q <= 1'b0;
            reset_q     <= 1'b0;
            commit_rd_q <= '0;
            res_q       <= '0;
            head_q      <= '0;
            flush_pc_q  <= '0;
        end else if (rdy) begin
            run_upd_q   <= 1'b0;
            st_commit_q <= 1'b0;
            reset_q     <= 1'b0;
            if (do_commit) begin
                head_q <= {1'b0, head_idx_q} + TW'(1);
                if (type_q[head_idx_q] == 2'd0) begin
                    run_upd_q   <= 1'b1;
                    commit_rd_q <= rd_q[head_idx_q];
                    res_q       <= val_q[head_idx_q];
                end else if (type_q[head_idx_q] == 2'd1) begin
                    st_commit_q <= 1'b1;
                end else if (type_q[head_idx_q] == 2'd2 &&
                             taken_q[head_idx_q] != pred_q[head_idx_q]) begin
                    reset_q    <= 1'b1;
                    flush_pc_q <= val_q[head_idx_q];
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer: issue, CDB, query bypass,
// in-order retire, full/wrap, mispredict flush, stall and reset.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  in_type = '0;
    logic [4:0]  in_rd = '0;
    logic        in_pred = 1'b0;
    logic        full;
    logic [4:0]  tail;
    logic [4:0]  q1_tag = '0, q2_tag = '0;
    logic        q1_rdy, q2_rdy;
    logic [31:0] q1_val, q2_val;
    logic        cdb_valid = 1'b0;
    logic [4:0]  cdb_tag = '0;
    logic [31:0] cdb_val = '0;
    logic        cdb_taken = 1'b0;
    logic        run_upd, st_commit, reset;
    logic [4:0]  commit_rd, head;
    logic [31:0] res, flush_pc;

    int total = 0;
    int bad = 0;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_valid(in_valid), .in_type(in_type), .in_rd(in_rd), .in_pred(in_pred),
        .full(full), .tail(tail),
        .q1_tag(q1_tag), .q2_tag(q2_tag),
        .q1_rdy(q1_rdy), .q2_rdy(q2_rdy), .q1_val(q1_val), .q2_val(q2_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .cdb_taken(cdb_taken),
        .run_upd(run_upd), .commit_rd(commit_rd), .res(res), .head(head),
        .st_commit(st_commit), .reset(reset), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        cdb_valid = 1'b0;
        cdb_taken = 1'b0;
        in_pred   = 1'b0;
        q1_tag    = '0;
        q2_tag    = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_run_upd", 32'(run_upd), 0);
        chk("rst_st_commit", 32'(st_commit), 0);
        chk("rst_reset", 32'(reset), 0);
        chk("rst_head", 32'(head), 0);
        chk("rst_res", res, 0);
        chk("rst_commit_rd", 32'(commit_rd), 0);
        chk("rst_flush_pc", flush_pc, 0);
        chk("rst_tail", 32'(tail), 1);
        chk("rst_full", 32'(full), 0);
        tick();
        rst = 1'b0;

        // single reg-write retire
        in_valid = 1'b1; in_type = 2'd0; in_rd = 5'd5;
        tick();
        in_valid = 1'b0;
        chk("t1_tail", 32'(tail), 2);
        cdb_valid = 1'b1; cdb_tag = 5'd1; cdb_val = 32'h1234; q1_tag = 5'd1;
        #1;
        chk("t1_byp_rdy", 32'(q1_rdy), 1);
        chk("t1_byp_val", q1_val, 32'h1234);
        tick();
        cdb_valid = 1'b0;
        #1;
        chk("t1_q_rdy", 32'(q1_rdy), 1);
        chk("t1_no_early", 32'(run_upd), 0);
        tick();
        chk("t1_run_upd", 32'(run_upd), 1);
        chk("t1_rd", 32'(commit_rd), 5);
        chk("t1_res", res, 32'h1234);
        chk("t1_head", 32'(head), 1);
        tick();
        chk("t1_pulse_end", 32'(run_upd), 0);

        // fill to 16, reject 17th, retire one, wrap tail
        do_reset();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_type = 2'd0; in_rd = 5'(i);
            tick();
        end
        chk("f_full", 32'(full), 1);
        chk("f_tail", 32'(tail), 1);
        tick();
        in_valid = 1'b0;
        chk("f_17_tail", 32'(tail), 1);
        chk("f_17_full", 32'(full), 1);
        cdb_valid = 1'b1; cdb_tag = 5'd1; cdb_val = 32'h11;
        tick();
        cdb_valid = 1'b0;
        chk("f_still_full", 32'(full), 1);
        chk("f_no_commit", 32'(run_upd), 0);
        tick();
        chk("f_run_upd", 32'(run_upd), 1);
        chk("f_head", 32'(head), 1);
        chk("f_res", res, 32'h11);
        chk("f_not_full", 32'(full), 0);
        chk("f_wrap_tail", 32'(tail), 1);
        in_valid = 1'b1; in_rd = 5'd9;
        tick();
        in_valid = 1'b0;
        chk("f_refull", 32'(full), 1);
        chk("f_tail2", 32'(tail), 2);

        // out-of-order CDB, in-order retire (tags 3 then 2)
        cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_val = 32'h33;
        tick();
        chk("o_wait1", 32'(run_upd), 0);
        cdb_tag = 5'd2; cdb_val = 32'h22;
        tick();
        chk("o_wait2", 32'(run_upd), 0);
        cdb_valid = 1'b0;
        tick();
        chk("o_c1_upd", 32'(run_upd), 1);
        chk("o_c1_head", 32'(head), 2);
        chk("o_c1_res", res, 32'h22);
        chk("o_c1_rd", 32'(commit_rd), 1);
        tick();
        chk("o_c2_upd", 32'(run_upd), 1);
        chk("o_c2_head", 32'(head), 3);
        chk("o_c2_res", res, 32'h33);
        chk("o_c2_rd", 32'(commit_rd), 2);
        tick();
        chk("o_idle", 32'(run_upd), 0);

        // mispredicted branch with 3 younger entries
        do_reset();
        in_valid = 1'b1; in_type = 2'd2; in_pred = 1'b0;
        tick();
        in_type = 2'd0; in_rd = 5'd10;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        chk("b_tail", 32'(tail), 5);
        cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_val = 32'hAB; q1_tag = 5'd3; q2_tag = 5'd4;
        #1;
        chk("q_byp_rdy", 32'(q1_rdy), 1);
        chk("q_byp_val", q1_val, 32'hAB);
        chk("q_other", 32'(q2_rdy), 0);
        q2_tag = 5'd0;
        #1;
        chk("q_tag0", 32'(q2_rdy), 0);
        tick();
        cdb_tag = 5'd1; cdb_val = 32'h80; cdb_taken = 1'b1;
        tick();
        cdb_valid = 1'b0; cdb_taken = 1'b0;
        chk("b_no_early", 32'(reset), 0);
        tick();
        chk("b_reset", 32'(reset), 1);
        chk("b_flush_pc", flush_pc, 32'h80);
        chk("b_head", 32'(head), 1);
        chk("b_no_upd", 32'(run_upd), 0);
        in_valid = 1'b1; in_type = 2'd0;
        tick();
        in_valid = 1'b0;
        #1;
        chk("b_pulse_end", 32'(reset), 0);
        chk("b_tail_clr", 32'(tail), 1);
        chk("b_full", 32'(full), 0);
        chk("b_q_cleared", 32'(q1_rdy), 0);
        tick();
        chk("b_no_commit", 32'(run_upd), 0);
        q1_tag = '0;

        // correct branch retires silently, then store
        in_valid = 1'b1; in_type = 2'd2; in_pred = 1'b1;
        tick();
        in_type = 2'd1;
        tick();
        in_valid = 1'b0;
        chk("s_tail", 32'(tail), 3);
        cdb_valid = 1'b1; cdb_tag = 5'd1; cdb_taken = 1'b1; cdb_val = 32'h44;
        tick();
        cdb_tag = 5'd2; cdb_taken = 1'b0; cdb_val = 32'h55;
        tick();
        chk("s_br_reset", 32'(reset), 0);
        chk("s_br_st", 32'(st_commit), 0);
        chk("s_br_upd", 32'(run_upd), 0);
        chk("s_br_head", 32'(head), 1);
        cdb_valid = 1'b0;
        tick();
        chk("s_st", 32'(st_commit), 1);
        chk("s_st_head", 32'(head), 2);
        tick();
        chk("s_st_end", 32'(st_commit), 0);

        // stall with ready head
        in_valid = 1'b1; in_type = 2'd0; in_rd = 5'd7;
        tick();
        in_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_val = 32'h77;
        tick();
        cdb_valid = 1'b0;
        rdy = 1'b0;
        tick();
        chk("r_hold_upd", 32'(run_upd), 0);
        chk("r_hold_head", 32'(head), 2);
        chk("r_hold_tail", 32'(tail), 4);
        tick();
        chk("r_hold_upd2", 32'(run_upd), 0);
        rdy = 1'b1;
        tick();
        chk("r_go_upd", 32'(run_upd), 1);
        chk("r_go_rd", 32'(commit_rd), 7);
        chk("r_go_res", res, 32'h77);
        chk("r_go_head", 32'(head), 3);

        // async reset mid-stream
        rst = 1'b1;
        #1;
        chk("m_upd", 32'(run_upd), 0);
        chk("m_head", 32'(head), 0);
        chk("m_res", res, 0);
        chk("m_rd", 32'(commit_rd), 0);
        chk("m_tail", 32'(tail), 1);
        tick();
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
